// File: rtl/axi4_arbiter2.sv
// Two-master to one-slave AXI4 arbiter: one burst outstanding at a time, round-robin grant
// held until the burst's response completes; channels are routed combinationally.
//
// state | meaning
// IDLE  | no burst outstanding, arbitrating between requesters
// AW    | write address of the granted master offered to the slave
// W     | write data beats, end of burst decided by beat count vs latched awlen
// B     | write response routed back to the granted master
// AR    | read address of the granted master offered to the slave
// R     | read data routed to the granted master until the last beat
module axi4_arbiter2 #(
   parameter int A_WIDTH = 26,
   parameter int D_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rstn,
   // master 0
   input  logic               m0_awvalid,
   output logic               m0_awready,
   input  logic [A_WIDTH-1:0] m0_awaddr,
   input  logic [7:0]         m0_awlen,
   input  logic               m0_wvalid,
   output logic               m0_wready,
   input  logic               m0_wlast,
   input  logic [D_WIDTH-1:0] m0_wdata,
   output logic               m0_bvalid,
   input  logic               m0_bready,
   input  logic               m0_arvalid,
   output logic               m0_arready,
   input  logic [A_WIDTH-1:0] m0_araddr,
   input  logic [7:0]         m0_arlen,
   output logic               m0_rvalid,
   input  logic               m0_rready,
   output logic               m0_rlast,
   output logic [D_WIDTH-1:0] m0_rdata,
   // master 1
   input  logic               m1_awvalid,
   output logic               m1_awready,
   input  logic [A_WIDTH-1:0] m1_awaddr,
   input  logic [7:0]         m1_awlen,
   input  logic               m1_wvalid,
   output logic               m1_wready,
   input  logic               m1_wlast,
   input  logic [D_WIDTH-1:0] m1_wdata,
   output logic               m1_bvalid,
   input  logic               m1_bready,
   input  logic               m1_arvalid,
   output logic               m1_arready,
   input  logic [A_WIDTH-1:0] m1_araddr,
   input  logic [7:0]         m1_arlen,
   output logic               m1_rvalid,
   input  logic               m1_rready,
   output logic               m1_rlast,
   output logic [D_WIDTH-1:0] m1_rdata,
   // slave
   output logic               s_awvalid,
   input  logic               s_awready,
   output logic [A_WIDTH-1:0] s_awaddr,
   output logic [7:0]         s_awlen,
   output logic               s_wvalid,
   input  logic               s_wready,
   output logic               s_wlast,
   output logic [D_WIDTH-1:0] s_wdata,
   input  logic               s_bvalid,
   output logic               s_bready,
   output logic               s_arvalid,
   input  logic               s_arready,
   output logic [A_WIDTH-1:0] s_araddr,
   output logic [7:0]         s_arlen,
   input  logic               s_rvalid,
   output logic               s_rready,
   input  logic               s_rlast,
   input  logic [D_WIDTH-1:0] s_rdata,
   // status
   output logic               busy,
   output logic               gnt
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AW   = 3'd1,
      S_W    = 3'd2,
      S_B    = 3'd3,
      S_AR   = 3'd4,
      S_R    = 3'd5
   } state_t;

   state_t       state_q, state_d;
   logic         gnt_q, gnt_d;
   logic         prio_q, prio_d;
   logic [7:0]   len_q, len_d;
   logic [7:0]   beat_q, beat_d;

   logic         req0, req1, win;
   logic         sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
   logic [7:0]   sel_awlen;
   logic         st_aw, st_w, st_b, st_ar, st_r;

   assign req0 = m0_awvalid | m0_arvalid;
   assign req1 = m1_awvalid | m1_arvalid;

   assign sel_awvalid = gnt_q ? m1_awvalid : m0_awvalid;
   assign sel_wvalid  = gnt_q ? m1_wvalid  : m0_wvalid;
   assign sel_bready  = gnt_q ? m1_bready  : m0_bready;
   assign sel_arvalid = gnt_q ? m1_arvalid : m0_arvalid;
   assign sel_rready  = gnt_q ? m1_rready  : m0_rready;
   assign sel_awlen   = gnt_q ? m1_awlen   : m0_awlen;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         gnt_q   <= 1'b0;
         prio_q  <= 1'b0;
         len_q   <= 8'd0;
         beat_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         prio_q  <= prio_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      prio_d  = prio_q;
      len_d   = len_q;
      beat_d  = beat_q;
      win     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               win    = (req0 & req1) ? prio_q : req1;
               gnt_d  = win;
               prio_d = ~win;
               // a write takes precedence over the same master's read
               state_d = (win ? m1_awvalid : m0_awvalid) ? S_AW : S_AR;
            end
         end
         S_AW: begin
            if (sel_awvalid & s_awready) begin
               len_d   = sel_awlen;
               beat_d  = 8'd0;
               state_d = S_W;
            end
         end
         S_W: begin
            if (sel_wvalid & s_wready) begin
               beat_d = beat_q + 8'd1;
               if (beat_q == len_q) state_d = S_B;
            end
         end
         S_B: begin
            if (s_bvalid & sel_bready) state_d = S_IDLE;
         end
         S_AR: begin
            if (sel_arvalid & s_arready) state_d = S_R;
         end
         S_R: begin
            if (s_rvalid & sel_rready & s_rlast) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign st_aw = (state_q == S_AW);
   assign st_w  = (state_q == S_W);
   assign st_b  = (state_q == S_B);
   assign st_ar = (state_q == S_AR);
   assign st_r  = (state_q == S_R);

   // slave side: payloads follow gnt always, valids/readys only in their own state
   assign s_awvalid = st_aw & sel_awvalid;
   assign s_awaddr  = gnt_q ? m1_awaddr : m0_awaddr;
   assign s_awlen   = sel_awlen;
   assign s_wvalid  = st_w & sel_wvalid;
   assign s_wdata   = gnt_q ? m1_wdata : m0_wdata;
   assign s_wlast   = gnt_q ? m1_wlast : m0_wlast;
   assign s_bready  = st_b & sel_bready;
   assign s_arvalid = st_ar & sel_arvalid;
   assign s_araddr  = gnt_q ? m1_araddr : m0_araddr;
   assign s_arlen   = gnt_q ? m1_arlen : m0_arlen;
   assign s_rready  = st_r & sel_rready;

   assign m0_awready = st_aw & ~gnt_q & s_awready;
   assign m1_awready = st_aw &  gnt_q & s_awready;
   assign m0_wready  = st_w  & ~gnt_q & s_wready;
   assign m1_wready  = st_w  &  gnt_q & s_wready;
   assign m0_bvalid  = st_b  & ~gnt_q & s_bvalid;
   assign m1_bvalid  = st_b  &  gnt_q & s_bvalid;
   assign m0_arready = st_ar & ~gnt_q & s_arready;
   assign m1_arready = st_ar &  gnt_q & s_arready;
   assign m0_rvalid  = st_r  & ~gnt_q & s_rvalid;
   assign m1_rvalid  = st_r  &  gnt_q & s_rvalid;

   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;
   assign m0_rlast = s_rlast;
   assign m1_rlast = s_rlast;

   assign busy = (state_q != S_IDLE);
   assign gnt  = gnt_q;

endmodule

// File: tb/tb_axi4_arbiter2.sv
// Bench for axi4_arbiter2: bench-side masters and slave, with a round-robin grant
// model computed from the pending requests of each master.
module tb_axi4_arbiter2;
   localparam int AW = 26;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   // master-side inputs, indexed by master
   logic [1:0]    m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
   logic [AW-1:0] m_awaddr [2];
   logic [AW-1:0] m_araddr [2];
   logic [7:0]    m_awlen  [2];
   logic [7:0]    m_arlen  [2];
   logic [DW-1:0] m_wdata  [2];

   // master-side outputs
   logic m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid;
   logic m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [1:0] o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
   logic [DW-1:0] o_rdata [2];
   assign o_awready = {m1_awready, m0_awready};
   assign o_wready  = {m1_wready,  m0_wready};
   assign o_bvalid  = {m1_bvalid,  m0_bvalid};
   assign o_arready = {m1_arready, m0_arready};
   assign o_rvalid  = {m1_rvalid,  m0_rvalid};
   assign o_rlast   = {m1_rlast,   m0_rlast};
   assign o_rdata[0] = m0_rdata;
   assign o_rdata[1] = m1_rdata;

   // slave side
   logic          s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
   logic          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [AW-1:0] s_awaddr, s_araddr;
   logic [7:0]    s_awlen, s_arlen;
   logic [DW-1:0] s_wdata, s_rdata;
   logic          busy, gnt;

   axi4_arbiter2 #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
      .clk(clk), .rstn(rstn),
      .m0_awvalid(m_awvalid[0]), .m0_awready(m0_awready), .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]),
      .m0_wvalid(m_wvalid[0]), .m0_wready(m0_wready), .m0_wlast(m_wlast[0]), .m0_wdata(m_wdata[0]),
      .m0_bvalid(m0_bvalid), .m0_bready(m_bready[0]),
      .m0_arvalid(m_arvalid[0]), .m0_arready(m0_arready), .m0_araddr(m_araddr[0]), .m0_arlen(m_arlen[0]),
      .m0_rvalid(m0_rvalid), .m0_rready(m_rready[0]), .m0_rlast(m0_rlast), .m0_rdata(m0_rdata),
      .m1_awvalid(m_awvalid[1]), .m1_awready(m1_awready), .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]),
      .m1_wvalid(m_wvalid[1]), .m1_wready(m1_wready), .m1_wlast(m_wlast[1]), .m1_wdata(m_wdata[1]),
      .m1_bvalid(m1_bvalid), .m1_bready(m_bready[1]),
      .m1_arvalid(m_arvalid[1]), .m1_arready(m1_arready), .m1_araddr(m_araddr[1]), .m1_arlen(m_arlen[1]),
      .m1_rvalid(m1_rvalid), .m1_rready(m_rready[1]), .m1_rlast(m1_rlast), .m1_rdata(m1_rdata),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata),
      .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast), .s_rdata(s_rdata),
      .busy(busy), .gnt(gnt)
   );

   int checks = 0;
   int errors = 0;
   bit prio_m = 1'b0;      // model: master favoured on the next tie
   bit pattern = 1'b0;     // write data 0x1111, 0x2222, ... instead of random
   bit full_speed = 1'b0;  // slave wready held high

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_other(input int o);
      chk("other_quiet", 32'({o_awready[o], o_wready[o], o_bvalid[o], o_arready[o], o_rvalid[o]}), 32'd0);
   endtask

   task automatic chk_all_quiet(input string tag);
      chk(tag, 32'({o_awready, o_wready, o_bvalid, o_arready, o_rvalid, s_awvalid, s_wvalid,
                    s_bready, s_arvalid, s_rready, busy}), 32'd0);
   endtask

   task automatic clear_inputs();
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
      for (int i = 0; i < 2; i++) begin
         m_awaddr[i] = '0; m_araddr[i] = '0; m_awlen[i] = '0; m_arlen[i] = '0; m_wdata[i] = '0;
      end
      s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = '0;
   endtask

   task automatic post_write(input int m, input logic [AW-1:0] addr, input logic [7:0] len);
      m_awvalid[m] = 1'b1; m_awaddr[m] = addr; m_awlen[m] = len;
   endtask

   task automatic post_read(input int m, input logic [AW-1:0] addr, input logic [7:0] len);
      m_arvalid[m] = 1'b1; m_araddr[m] = addr; m_arlen[m] = len;
   endtask

   // Called one time unit after an edge with the arbiter idle; serves exactly one burst
   // and returns one time unit after the completing edge.
   task automatic serve_next();
      bit r0, r1, is_wr, done;
      int w, o, len, cnt, n;
      r0 = m_awvalid[0] | m_arvalid[0];
      r1 = m_awvalid[1] | m_arvalid[1];
      if (!(r0 || r1)) return;
      w = (r0 && r1) ? int'(prio_m) : (r1 ? 1 : 0);
      o = 1 - w;
      prio_m = (o == 1);
      is_wr = m_awvalid[w];
      chk("idle_before_grant", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("gnt", 32'(gnt), 32'(w));
      chk("busy_on_grant", 32'(busy), 32'd1);
      if (is_wr) begin
         len = int'(m_awlen[w]);
         done = 0; n = 0;
         while (!done && n < 50) begin
            s_awready = 1'($urandom_range(0, 1)); #1;
            chk("s_awvalid", 32'(s_awvalid), 32'd1);
            chk("s_awaddr", 32'(s_awaddr), 32'(m_awaddr[w]));
            chk("s_awlen", 32'(s_awlen), 32'(m_awlen[w]));
            chk("s_arvalid_in_aw", 32'(s_arvalid), 32'd0);
            chk("awready", 32'(o_awready[w]), 32'(s_awready));
            chk_other(o);
            done = s_awready;
            @(posedge clk); #1; n++;
         end
         if (!done) chk("aw_timeout", 32'd0, 32'd1);
         m_awvalid[w] = 0; s_awready = 0;
         cnt = 0; n = 0;
         while (cnt <= len && n < 400) begin
            m_wvalid[w] = 1;
            m_wdata[w] = pattern ? DW'((cnt + 1) * 16'h1111) : DW'($urandom);
            m_wlast[w] = (cnt == len);
            s_wready = full_speed ? 1'b1 : 1'($urandom_range(0, 1)); #1;
            chk("s_wvalid", 32'(s_wvalid), 32'd1);
            chk("s_wdata", 32'(s_wdata), 32'(m_wdata[w]));
            chk("s_wlast", 32'(s_wlast), 32'(m_wlast[w]));
            chk("wready", 32'(o_wready[w]), 32'(s_wready));
            chk("busy_w", 32'(busy), 32'd1);
            chk_other(o);
            if (s_wready) cnt++;
            @(posedge clk); #1; n++;
         end
         if (cnt <= len) chk("w_timeout", 32'd0, 32'd1);
         // one extra beat offered: the burst must already have left W
         s_wready = 1; m_wlast[w] = 0; #1;
         chk("w_exit_valid", 32'(s_wvalid), 32'd0);
         chk("w_exit_ready", 32'(o_wready[w]), 32'd0);
         m_wvalid[w] = 0; s_wready = 0;
         done = 0; n = 0; m_bready[w] = 1;
         while (!done && n < 50) begin
            s_bvalid = (n >= 2) ? 1'b1 : 1'($urandom_range(0, 1)); #1;
            chk("bvalid", 32'(o_bvalid[w]), 32'(s_bvalid));
            chk("s_bready", 32'(s_bready), 32'd1);
            chk("busy_b", 32'(busy), 32'd1);
            chk_other(o);
            done = s_bvalid;
            @(posedge clk); #1; n++;
         end
         if (!done) chk("b_timeout", 32'd0, 32'd1);
         s_bvalid = 0; m_bready[w] = 0;
      end else begin
         len = int'(m_arlen[w]);
         done = 0; n = 0;
         while (!done && n < 50) begin
            s_arready = 1'($urandom_range(0, 1)); #1;
            chk("s_arvalid", 32'(s_arvalid), 32'd1);
            chk("s_araddr", 32'(s_araddr), 32'(m_araddr[w]));
            chk("s_arlen", 32'(s_arlen), 32'(m_arlen[w]));
            chk("s_awvalid_in_ar", 32'(s_awvalid), 32'd0);
            chk("arready", 32'(o_arready[w]), 32'(s_arready));
            chk_other(o);
            done = s_arready;
            @(posedge clk); #1; n++;
         end
         if (!done) chk("ar_timeout", 32'd0, 32'd1);
         m_arvalid[w] = 0; s_arready = 0;
         cnt = 0; n = 0; done = 0;
         while (!done && n < 400) begin
            s_rvalid = 1'($urandom_range(0, 1));
            s_rdata = DW'($urandom);
            s_rlast = (cnt == len);
            m_rready[w] = ($urandom_range(0, 3) != 0); #1;
            chk("rvalid", 32'(o_rvalid[w]), 32'(s_rvalid));
            chk("rdata", 32'(o_rdata[w]), 32'(s_rdata));
            chk("rdata_bcast", 32'(o_rdata[o]), 32'(s_rdata));
            chk("rlast", 32'(o_rlast[w]), 32'(s_rlast));
            chk("s_rready", 32'(s_rready), 32'(m_rready[w]));
            chk_other(o);
            if (s_rvalid && m_rready[w]) begin
               if (cnt == len) done = 1;
               cnt++;
            end
            @(posedge clk); #1; n++;
         end
         if (!done) chk("r_timeout", 32'd0, 32'd1);
         s_rvalid = 0; s_rlast = 0; m_rready[w] = 0;
      end
      chk("idle_after_burst", 32'(busy), 32'd0);
   endtask

   initial begin
      int k, guard;
      clear_inputs();
      rstn = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_quiet("reset_outputs");
      chk("reset_gnt", 32'(gnt), 32'd0);
      rstn = 1;

      // directed write from m0, patterned data, full-speed slave
      pattern = 1; full_speed = 1;
      post_write(0, AW'(26'h100), 8'd3);
      serve_next();
      pattern = 0; full_speed = 0;

      // single-beat read from m1
      post_read(1, AW'(26'h40), 8'd0);
      serve_next();

      // simultaneous reads after reset alternate m0, m1, m0, m1
      rstn = 0; @(posedge clk); #1; rstn = 1; prio_m = 0;
      for (int rep = 0; rep < 2; rep++) begin
         post_read(0, AW'($urandom), 8'($urandom_range(0, 3)));
         post_read(1, AW'($urandom), 8'($urandom_range(0, 3)));
         serve_next();
         serve_next();
      end

      // same master with aw and ar: write first
      post_write(0, AW'(26'h200), 8'd1);
      post_read(0, AW'(26'h300), 8'd2);
      serve_next();
      serve_next();

      // back-pressured 16-beat write
      post_write(1, AW'(26'h1000), 8'd15);
      serve_next();

      // reset during W at beat 2
      post_write(0, AW'(26'h80), 8'd5);
      @(posedge clk); #1;
      s_awready = 1;
      @(posedge clk); #1;
      m_awvalid[0] = 0; s_awready = 0;
      m_wvalid[0] = 1; s_wready = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("busy_mid_w", 32'(busy), 32'd1);
      rstn = 0;
      @(posedge clk); #1;
      chk_all_quiet("reset_mid_w");
      clear_inputs();
      rstn = 1; prio_m = 0;
      post_read(1, AW'(26'h44), 8'd1);
      serve_next();

      // randomized mix of requests
      for (int it = 0; it < 25; it++) begin
         for (int m = 0; m < 2; m++) begin
            k = $urandom_range(0, 3);
            if (k[0]) post_write(m, AW'($urandom), 8'($urandom_range(0, 15)));
            if (k[1]) post_read(m, AW'($urandom), 8'($urandom_range(0, 15)));
         end
         if (!(|m_awvalid || |m_arvalid)) post_read(0, AW'($urandom), 8'($urandom_range(0, 15)));
         guard = 0;
         while ((|m_awvalid || |m_arvalid) && guard < 8) begin
            serve_next();
            guard++;
         end
         if (|m_awvalid || |m_arvalid) chk("random_drain", 32'd0, 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
